// File: rtl/ra_update_sequencer.sv
// Rule-update sequencer: issues load/sel strobes in LFSR-random (RA) or round-robin (CA) order
// until the requested number of rounds over all rules has been completed.
module ra_update_sequencer #(
    parameter int unsigned RULES   = 68,
    parameter int unsigned R_LOG_2 = 7,
    parameter int unsigned LFSR_W  = 10,
    parameter int unsigned GROUP   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [9:0]         num_rounds,
    input  logic [LFSR_W-1:0]  seed,
    input  logic               stall,
    output logic               load,
    output logic [R_LOG_2-1:0] sel,
    output logic [9:0]         iteration_number,
    output logic [9:0]         round_number,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LFSR_W-1:0]  lfsr_d;
    logic [R_LOG_2-1:0] ca_ptr_q;
    logic [R_LOG_2-1:0] ca_ptr_d;
    logic [R_LOG_2-1:0] upd_cnt_q;
    logic [CNT_W-1:0]   iter_q;
    logic [CNT_W-1:0]   round_q;
    logic [CNT_W-1:0]   nrounds_q;
    logic               mode_q;

    logic [LFSR_W-1:0]  ra_quot;
    logic [R_LOG_2-1:0] cand;
    logic               valid;
    logic               target_met;
    logic               last_of_round;

    // x^10 + x^7 + 1 Fibonacci step, shifting left
    assign lfsr_d        = {lfsr_q[LFSR_W-2:0], lfsr_q[9] ^ lfsr_q[6]};
    assign ca_ptr_d      = (ca_ptr_q == R_LOG_2'(RULES - 1)) ? '0 : ca_ptr_q + R_LOG_2'(1);

    // RA candidates at or above RULES*GROUP map to no rule and are skipped
    assign ra_quot       = lfsr_q / LFSR_W'(GROUP);
    assign cand          = mode_q ? ca_ptr_q : R_LOG_2'(ra_quot);
    assign valid         = mode_q | (ra_quot < LFSR_W'(RULES));
    assign target_met    = (round_q == nrounds_q);
    assign last_of_round = (upd_cnt_q == R_LOG_2'(RULES - 1));

    assign load             = (state_q == RUN) & ~stall & valid & ~target_met;
    assign sel              = load ? cand : '0;
    assign iteration_number = iter_q;
    assign round_number     = round_q;
    assign busy             = (state_q == RUN);
    assign done             = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_W'(1);
            ca_ptr_q  <= '0;
            upd_cnt_q <= '0;
            iter_q    <= '0;
            round_q   <= '0;
            nrounds_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= RUN;
                        lfsr_q    <= (seed == '0) ? LFSR_W'(1) : seed;
                        upd_cnt_q <= '0;
                        iter_q    <= '0;
                        round_q   <= '0;
                        nrounds_q <= num_rounds;
                        mode_q    <= mode;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (target_met) begin
                            state_q <= DONE;
                        end else begin
                            if (!mode_q) begin
                                lfsr_q <= lfsr_d;
                            end
                            if (load) begin
                                iter_q <= iter_q + CNT_W'(1);
                                if (mode_q) begin
                                    ca_ptr_q <= ca_ptr_d;
                                end
                                if (last_of_round) begin
                                    upd_cnt_q <= '0;
                                    round_q   <= round_q + CNT_W'(1);
                                    // finishing the requested round ends the run on this edge
                                    if ((round_q + CNT_W'(1)) == nrounds_q) begin
                                        state_q <= DONE;
                                    end
                                end else begin
                                    upd_cnt_q <= upd_cnt_q + R_LOG_2'(1);
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ra_update_sequencer.sv
// Randomized bench for ra_update_sequencer against a cycle-level behavioural model
// of the run/round bookkeeping and the RA/CA candidate streams.
module tb_ra_update_sequencer;

    localparam int RULES = 68;
    localparam int GROUP = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [9:0] num_rounds;
    logic [9:0] seed;
    logic       stall;
    logic       load;
    logic [6:0] sel;
    logic [9:0] iteration_number;
    logic [9:0] round_number;
    logic       busy;
    logic       done;

    ra_update_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .num_rounds       (num_rounds),
        .seed             (seed),
        .stall            (stall),
        .load             (load),
        .sel              (sel),
        .iteration_number (iteration_number),
        .round_number     (round_number),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state: 0 = idle, 1 = run, 2 = done
    int m_st, m_lfsr, m_ptr, m_upd, m_iter, m_round, m_mode, m_nr;
    int obs_load, obs_sel;
    int log_q[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int l);
        return ((l << 1) & 1023) | (((l >> 9) ^ (l >> 6)) & 1);
    endfunction

    function automatic int m_cand();
        return (m_mode != 0) ? m_ptr : m_lfsr / GROUP;
    endfunction

    function automatic int m_load();
        return (m_st == 1 && !stall && ((m_mode != 0) || (m_lfsr / GROUP) < RULES)
                && m_round != m_nr) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int ld;
        ld = m_load();
        if (rst) begin
            m_st = 0; m_lfsr = 1; m_ptr = 0; m_upd = 0; m_iter = 0; m_round = 0;
        end else if (m_st != 1) begin
            if (start) begin
                m_st = 1;
                m_lfsr = (seed == 0) ? 1 : int'(seed);
                m_upd = 0; m_iter = 0; m_round = 0;
                m_mode = int'(mode); m_nr = int'(num_rounds);
            end
        end else if (!stall) begin
            if (m_round == m_nr) begin
                m_st = 2;
            end else begin
                if (ld != 0) begin
                    m_iter = (m_iter + 1) % 1024;
                    m_upd++;
                    if (m_upd == RULES) begin
                        m_upd = 0;
                        m_round++;
                        if (m_round == m_nr) m_st = 2;
                    end
                    if (m_mode != 0) m_ptr = (m_ptr + 1) % RULES;
                end
                if (m_mode == 0) m_lfsr = lfsr_next(m_lfsr);
            end
        end
    endtask

    // inputs are already driven; compare outputs, then advance one clock
    task automatic tick();
        #1;
        obs_load = int'(load);
        obs_sel  = int'(sel);
        check_eq("load", obs_load, m_load());
        check_eq("sel", obs_sel, (m_load() != 0) ? m_cand() : 0);
        check_eq("iteration_number", int'(iteration_number), m_iter);
        check_eq("round_number", int'(round_number), m_round);
        check_eq("busy", int'(busy), (m_st == 1) ? 1 : 0);
        check_eq("done", int'(done), (m_st == 2) ? 1 : 0);
        if (obs_load != 0) log_q.push_back(obs_sel);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic launch(input int md, input int nr, input int sd);
        log_q.delete();
        start = 1'b1; mode = md[0]; num_rounds = nr[9:0]; seed = sd[9:0];
        tick();
        start = 1'b0;
        mode = 1'($urandom); num_rounds = 10'($urandom); seed = 10'($urandom);
    endtask

    task automatic run(input int budget, input int stall_pct, input bit start_noise);
        for (int i = 0; i < budget && m_st == 1; i++) begin
            stall = ($urandom_range(99) < stall_pct);
            if (start_noise) begin
                start = 1'($urandom); mode = 1'($urandom);
                num_rounds = 10'($urandom); seed = 10'($urandom);
            end
            tick();
        end
        stall = 1'b0;
        start = 1'b0;
        if (m_st == 1) check_eq("run_timeout_busy", int'(busy), 0);
    endtask

    int ref_q[$];
    int nostall_q[$];
    int md, nr, sd;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; num_rounds = '0; seed = '0; stall = 1'b0;
        m_st = 0; m_lfsr = 1; m_ptr = 0; m_upd = 0; m_iter = 0; m_round = 0; m_mode = 0; m_nr = 0;
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        tick();

        // CA, two rounds: strict round-robin
        launch(1, 2, 0);
        run(1000, 0, 1'b0);
        check_eq("ca_loads", log_q.size(), 136);
        foreach (log_q[i]) check_eq("ca_sel_order", log_q[i], i % RULES);
        check_eq("ca_iter_final", int'(iteration_number), 136);
        check_eq("ca_round_final", int'(round_number), 2);
        check_eq("ca_done", int'(done), 1);
        for (int i = 0; i < 3; i++) tick();

        // RA, seed 1, one round
        launch(0, 1, 1);
        run(1000, 0, 1'b0);
        check_eq("ra1_loads", log_q.size(), 68);
        check_eq("ra1_iter_final", int'(iteration_number), 68);
        ref_q = log_q;

        // seed 0 behaves as seed 1
        launch(0, 1, 0);
        run(1000, 0, 1'b0);
        check_eq("seed0_len", log_q.size(), ref_q.size());
        foreach (log_q[i]) if (i < ref_q.size()) check_eq("seed0_sel", log_q[i], ref_q[i]);

        // 5-cycle stall mid-run resumes the identical sequence
        sd = int'($urandom_range(1, 1023));
        launch(0, 2, sd);
        run(2000, 0, 1'b0);
        nostall_q = log_q;
        launch(0, 2, sd);
        for (int i = 0; i < 40; i++) tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b0;
        run(2000, 0, 1'b0);
        check_eq("stall_len", log_q.size(), nostall_q.size());
        foreach (log_q[i]) if (i < nostall_q.size()) check_eq("stall_sel", log_q[i], nostall_q[i]);

        // zero rounds: a single idle RUN cycle then DONE
        launch(0, 0, 5);
        check_eq("nr0_busy", int'(busy), 1);
        tick();
        check_eq("nr0_done", int'(done), 1);
        check_eq("nr0_loads", log_q.size(), 0);
        tick();

        // reset mid-run at iteration 30, rst beating start, then replay
        sd = int'($urandom_range(0, 1023));
        launch(0, 3, sd);
        for (int i = 0; i < 200 && m_iter != 30; i++) tick();
        check_eq("rst_reach30", int'(iteration_number), 30);
        ref_q = log_q;
        rst = 1'b1; start = 1'b1; mode = 1'b1; num_rounds = 10'd4;
        tick();
        rst = 1'b0; start = 1'b0;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_iter", int'(iteration_number), 0);
        tick();
        tick();
        launch(0, 3, sd);
        run(3000, 0, 1'b0);
        foreach (ref_q[i]) if (i < log_q.size()) check_eq("rst_replay_sel", log_q[i], ref_q[i]);

        // random runs with stalls and ignored start pulses
        for (int r = 0; r < 6; r++) begin
            md = int'($urandom_range(0, 1));
            nr = int'($urandom_range(1, 3));
            sd = int'($urandom_range(0, 1023));
            launch(md, nr, sd);
            run(4000, 25, 1'b1);
            check_eq("rand_loads", log_q.size(), nr * RULES);
            check_eq("rand_round", int'(round_number), nr);
            for (int i = 0; i < 2; i++) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
